// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// state encoding and the LO fill pattern written on a divide by zero.
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    // Every bit of LO is set to this value when the divisor is zero.
    localparam logic MD_DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer handshake and result bus.
// master = EX stage (issues operations), slave = the sequencer.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);

    logic             start_mult;
    logic             start_div;
    logic             signed_op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             hilo_we;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start_mult, start_div, signed_op, opa, opb, flush,
        input  stall, busy, hilo_we, hi_out, lo_out
    );

    modport slave (
        input  start_mult, start_div, signed_op, opa, opb, flush,
        output stall, busy, hilo_we, hi_out, lo_out
    );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring radix-2 division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and shift the resulting quotient bit into quo.
module muldiv_ctrl_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;

    // Top bit of the trial difference is the borrow: set means restore.
    always_comb begin
        partial = {rem_in, quo_in[WIDTH-1]};
        trial   = partial - {1'b0, divisor};
        if (trial[WIDTH]) begin
            rem_out = partial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = trial[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage MULT/MULTU/DIV/DIVU sequencer. Stalls IF..EX while a
// fixed-latency multiply or a bit-serial restoring divide runs, then
// pulses hilo_we for one cycle. A flush abandons the operation unwritten.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input logic          clk,
    input logic          rst,
    muldiv_ctrl_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t state;
    md_state_t state_next;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               signed_q;
    logic               qsign_q;
    logic               rsign_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod_comb;
    logic [2*WIDTH-1:0] prod_final;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    // Divide works on magnitudes; the most negative value maps onto itself,
    // which is exactly its unsigned magnitude.
    assign abs_a = (bus.signed_op && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    assign abs_b = (bus.signed_op && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

    // Extending to 2*WIDTH before multiplying gives the full signed or
    // unsigned product in the low 2*WIDTH bits.
    assign ext_a     = signed_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
    assign ext_b     = signed_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
    assign prod_comb = ext_a * ext_b;

    // The HI/LO register is the last multiply stage; any extra stages sit here.
    generate
        if (MUL_LAT > 1) begin : g_mul_pipe
            logic [2*WIDTH-1:0] pipe [MUL_LAT-1];

            // Product shift chain between the operand latch and HI/LO.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT-1; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= prod_comb;
                    for (int i = 1; i < MUL_LAT-1; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign prod_final = pipe[MUL_LAT-2];
        end else begin : g_mul_comb
            assign prod_final = prod_comb;
        end
    endgenerate

    muldiv_ctrl_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .quo_in  (opa_q),
        .divisor (opb_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign rem_fix = rsign_q ? -step_rem : step_rem;
    assign quo_fix = qsign_q ? -step_quo : step_quo;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_next;
    end

    // Next-state: flush always returns to IDLE; divide start wins over multiply.
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (bus.start_div)       state_next = (bus.opb == '0) ? MD_DONE : MD_DIV;
                    else if (bus.start_mult) state_next = MD_MUL;
                end
                MD_MUL:  if (cnt == CW'(1)) state_next = MD_DONE;
                MD_DIV:  if (cnt == CW'(1)) state_next = MD_DONE;
                MD_DONE: state_next = MD_IDLE;
                default: state_next = MD_IDLE;
            endcase
        end
    end

    // Pipeline controls: stall drops in DONE so the instruction advances as HI/LO is written.
    always_comb begin
        bus.busy    = (state != MD_IDLE);
        bus.hilo_we = (state == MD_DONE) && !bus.flush;
        bus.stall   = !bus.flush &&
                      (((state == MD_IDLE) && (bus.start_mult || bus.start_div)) ||
                       (state == MD_MUL) || (state == MD_DIV));
    end

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

    // Operand latch, divide iteration and HI/LO update on the way into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            signed_q <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (bus.start_div && !bus.flush) begin
                        opa_q   <= abs_a;
                        opb_q   <= abs_b;
                        rem_q   <= '0;
                        qsign_q <= bus.signed_op & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
                        rsign_q <= bus.signed_op & bus.opa[WIDTH-1];
                        cnt     <= CW'(WIDTH);
                        if (bus.opb == '0) begin
                            hi_q <= bus.opa;
                            lo_q <= {WIDTH{MD_DIV0_LO_BIT}};
                        end
                    end else if (bus.start_mult && !bus.flush) begin
                        opa_q    <= bus.opa;
                        opb_q    <= bus.opb;
                        signed_q <= bus.signed_op;
                        cnt      <= CW'(MUL_LAT);
                    end
                end
                MD_MUL: begin
                    cnt <= cnt - CW'(1);
                    if (state_next == MD_DONE) begin
                        hi_q <= prod_final[2*WIDTH-1:WIDTH];
                        lo_q <= prod_final[WIDTH-1:0];
                    end
                end
                MD_DIV: begin
                    rem_q <= step_rem;
                    opa_q <= step_quo;
                    cnt   <= cnt - CW'(1);
                    if (state_next == MD_DONE) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO and latency model.
module tb_muldiv_ctrl;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;

    logic [31:0] last_hi;
    logic [31:0] last_lo;

    muldiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

    muldiv_ctrl #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Global guard so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // {HI,LO} from the instruction definitions using 64-bit integer arithmetic.
    function automatic logic [63:0] refResult(input bit is_div, input bit sgn,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        if (is_div) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        p = sa * sb;
        return p;
    endfunction

    function automatic int refLatency(input bit is_div, input logic [31:0] b);
        if (!is_div)      return MUL_LAT + 1;
        if (b == 32'd0)   return 1;
        return WIDTH + 1;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation, hold start while stalled, check timing and result.
    task automatic applyStimulus(input bit is_div, input bit both, input bit sgn,
                                 input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int          exp_lat;
        int          cycle;
        int          stall_cycles;
        bit          seen;
        exp     = refResult(is_div, sgn, a, b);
        exp_lat = refLatency(is_div, b);
        @(negedge clk);
        bus.start_div  = is_div;
        bus.start_mult = !is_div || both;
        bus.signed_op  = sgn;
        bus.opa        = a;
        bus.opb        = b;
        #1;
        cycle        = 0;
        stall_cycles = 0;
        seen         = 1'b0;
        while (!seen && cycle <= 100) begin
            if (bus.hilo_we) begin
                seen = 1'b1;
            end else begin
                if (bus.stall) stall_cycles++;
                @(negedge clk);
                cycle++;
            end
        end
        checkOutput({tag, " write seen"}, 64'(seen), 64'd1);
        checkOutput({tag, " latency"}, 64'(cycle), 64'(exp_lat));
        checkOutput({tag, " stall cycles"}, 64'(stall_cycles), 64'(exp_lat));
        checkOutput({tag, " stall in done"}, 64'(bus.stall), 64'd0);
        checkOutput({tag, " hi"}, 64'(bus.hi_out), 64'(exp[63:32]));
        checkOutput({tag, " lo"}, 64'(bus.lo_out), 64'(exp[31:0]));
        last_hi = exp[63:32];
        last_lo = exp[31:0];
        bus.start_div  = 1'b0;
        bus.start_mult = 1'b0;
        @(negedge clk);
        checkOutput({tag, " strobe width"}, 64'(bus.hilo_we), 64'd0);
        checkOutput({tag, " idle after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int hits;
        bit r_div;
        bit r_sgn;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst            = 1'b1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.signed_op  = 1'b0;
        bus.opa        = '0;
        bus.opb        = '0;
        bus.flush      = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset stall", 64'(bus.stall), 64'd0);
        checkOutput("reset hilo_we", 64'(bus.hilo_we), 64'd0);
        checkOutput("reset hi", 64'(bus.hi_out), 64'd0);
        checkOutput("reset lo", 64'(bus.lo_out), 64'd0);
        rst = 1'b0;

        applyStimulus(0, 0, 0, 32'hFFFF_FFFF, 32'd2, "multu max x 2");
        applyStimulus(0, 0, 1, 32'hFFFF_FFFD, 32'd7, "mult -3 x 7");
        applyStimulus(1, 0, 1, 32'hFFFF_FFF9, 32'd2, "div -7 / 2");
        applyStimulus(1, 0, 0, 32'd100, 32'd7, "divu 100 / 7");
        applyStimulus(1, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div min / -1");
        applyStimulus(1, 0, 0, 32'd5, 32'd0, "divu 5 / 0");
        applyStimulus(1, 0, 1, 32'd7, 32'hFFFF_FFFE, "div 7 / -2");

        // Divide flushed at cycle 10: no write, HI/LO untouched.
        @(negedge clk);
        bus.start_div = 1'b1;
        bus.signed_op = 1'b1;
        bus.opa       = 32'hFFFF_FFF9;
        bus.opb       = 32'd2;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush div stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.start_div = 1'b0;
        checkOutput("flush div idle", 64'(bus.busy), 64'd0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.hilo_we) hits++;
        end
        checkOutput("flush div no write", 64'(hits), 64'd0);
        checkOutput("flush div hi kept", 64'(bus.hi_out), 64'(last_hi));
        checkOutput("flush div lo kept", 64'(bus.lo_out), 64'(last_lo));
        applyStimulus(0, 0, 0, 32'd3, 32'd4, "multu 3 x 4 after flush");

        // Start together with flush in IDLE is ignored.
        @(negedge clk);
        bus.start_mult = 1'b1;
        bus.flush      = 1'b1;
        bus.opa        = 32'd9;
        bus.opb        = 32'd9;
        #1;
        checkOutput("flush idle stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        checkOutput("flush idle busy", 64'(bus.busy), 64'd0);
        bus.start_mult = 1'b0;
        bus.flush      = 1'b0;

        // Flush landing in DONE suppresses the write strobe.
        @(negedge clk);
        bus.start_mult = 1'b1;
        bus.signed_op  = 1'b0;
        bus.opa        = 32'd5;
        bus.opb        = 32'd6;
        repeat (MUL_LAT + 1) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checkOutput("flush done hilo_we", 64'(bus.hilo_we), 64'd0);
        bus.start_mult = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        checkOutput("flush done idle", 64'(bus.busy), 64'd0);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.hilo_we) hits++;
        end
        checkOutput("flush done no write", 64'(hits), 64'd0);

        // Reset in the middle of a divide overrides everything.
        @(negedge clk);
        bus.start_div = 1'b1;
        bus.signed_op = 1'b0;
        bus.opa       = 32'd1000;
        bus.opb       = 32'd3;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid reset busy", 64'(bus.busy), 64'd0);
        checkOutput("mid reset hilo_we", 64'(bus.hilo_we), 64'd0);
        checkOutput("mid reset hi", 64'(bus.hi_out), 64'd0);
        checkOutput("mid reset lo", 64'(bus.lo_out), 64'd0);
        rst           = 1'b0;
        bus.start_div = 1'b0;
        #1;
        checkOutput("mid reset stall", 64'(bus.stall), 64'd0);

        // Both starts high: the divide runs.
        applyStimulus(1, 1, 0, 32'd100, 32'd7, "both starts div");

        for (int n = 0; n < 24; n++) begin
            r_div = 1'($urandom_range(0, 1));
            r_sgn = 1'($urandom_range(0, 1));
            r_a   = pickOperand();
            r_b   = pickOperand();
            applyStimulus(r_div, 0, r_sgn, r_a, r_b, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Execute-stage sequencer for MULT/MULTU/DIV/DIVU. It accepts a start pulse from EX and holds the pipeline with a stall for as long as it needs. It runs a fixed-latency multiply or a restoring radix-2 divide, then issues a one-cycle HI/LO write (the decoder's hilowrite=11 path). A pipeline flush from an exception or ERET aborts any operation in flight without writing HI/LO.

Parameters:
WIDTH, 32, operand width; the product and {HI,LO} pair are 2*WIDTH.
MUL_LAT, 2, cycles spent in MUL state (≥1).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start_mult  in  1  EX holds MULT/MULTU (sampled only in IDLE)
start_div  in  1  EX holds DIV/DIVU (sampled only in IDLE)
signed_op  in  1  1 = MULT/DIV, 0 = MULTU/DIVU
opa  in  WIDTH  rs operand (dividend / multiplicand)
opb  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  pipeline flush (exception/ERET), abort
stall  out  1  freeze IF..EX
busy  out  1  state != IDLE
hilo_we  out  1  one-cycle HI/LO write strobe
hi_out  out  WIDTH  HI result (remainder / product[2W-1:W])
lo_out  out  WIDTH  LO result (quotient / product[W-1:0])

Behaviour:
- Reset: one clk with rst=1 → state IDLE. stall, busy, hilo_we = 0. hi_out, lo_out, counter and operand registers = 0.
- States:
  - IDLE, MUL, DIV, DONE; 2-bit encoding.
  - Counter is log2(WIDTH)+1 bits.
- IDLE:
  - start_div & ~flush: latch |opa|, |opb| (absolute values if signed_op), the quotient sign (a[W-1]^b[W-1]) and the remainder sign (a[W-1]).
  - If opb != 0 → DIV with cnt=WIDTH.
  - If opb == 0 → DONE with hi=opa, lo={WIDTH{1}}.
  - start_mult & ~flush (and no start_div) → MUL with cnt=MUL_LAT and latched operands.
  - start_div has priority when both starts are high.
- MUL:
  - Full 2W-bit product: signed when signed_op, else unsigned. Registered through MUL_LAT stages.
  - cnt decrements each cycle; at cnt==1 → DONE.
- DIV:
  - One restoring step per cycle: shift {rem,quo} left by 1, trial-subtract divisor, set the quotient bit.
  - After WIDTH steps → DONE.
  - Sign fix-up is applied on entry to DONE: negate quo if qsign, negate rem if rsign.
  - 0x80000000 / -1 (signed) gives quo=0x80000000, rem=0 (wraparound, no trap).
- DONE: hilo_we=1 for exactly one cycle with hi_out/lo_out valid, then → IDLE. hi_out/lo_out hold their value until the next DONE.
- stall (combinational):
  - stall = ~flush & ((IDLE & (start_mult|start_div)) | MUL | DIV).
  - It is low in DONE, so the instruction advances in the cycle HI/LO is written.
- Latency from the start cycle (cycle 0, stall=1):
  - mult: hilo_we at cycle MUL_LAT+1, so MUL_LAT+1 stall cycles.
  - div: hilo_we at cycle WIDTH+1 (33).
  - div-by-zero: hilo_we at cycle 1.
- flush:
  - In any state: next state IDLE, no hilo_we that cycle or later, stall low the same cycle.
  - flush in DONE suppresses hilo_we.
  - flush in IDLE together with a start ignores the start.
- A start while busy is ignored; EX is stalled, so it is the same instruction.
- rst mid-operation: behaves as reset and overrides flush and start.

Decomposition:
- Shared package/header (defines.vh): state encodings MD_IDLE/MD_MUL/MD_DIV/MD_DONE and the default DIV-by-zero LO pattern.
- One sub-module, div_step: combinational single restoring iteration {rem_in, quo_in, divisor} → {rem_out, quo_out}.
- The multiply pipeline stays inline.

Test Plan:
1. MULTU opa=0xFFFFFFFF, opb=2 → stall for 3 cycles, then hilo_we=1 with hi=0x00000001, lo=0xFFFFFFFE.
2. MULT opa=-3 (0xFFFFFFFD), opb=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
3. DIV opa=-7, opb=2 → hilo_we at cycle 33 with lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 → lo=14, hi=2.
4. DIV opa=0x80000000, opb=-1 → lo=0x80000000, hi=0. DIVU 5/0 → cycle 1: hi=5, lo=0xFFFFFFFF.
5. DIV start, then flush at cycle 10 → stall low that cycle, IDLE next cycle, no hilo_we for 40 cycles. A new MULTU 3×4 then completes with lo=12.
6. rst at cycle 5 of a DIV → next cycle busy=0, stall=0, hi_out=lo_out=0. start_mult and start_div together → a DIV runs.
